// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared types and constants for the multiplexed FSMC bus master
package fsmc_pkg;

    localparam int FSMC_ADDR_W = 19;
    localparam int FSMC_DATA_W = 16;
    localparam int TIMER_W     = 8;

    localparam int DEF_ADDSET  = 2;
    localparam int DEF_ADDHLD  = 1;
    localparam int DEF_DATAST  = 4;
    localparam int DEF_BUSTURN = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_AHOLD = 3'd2,
        ST_DATA  = 3'd3,
        ST_DHOLD = 3'd4,
        ST_TURN  = 3'd5
    } fsmc_state_e;

    // A phase of N cycles loads N-1 so the terminal count lands on its last cycle.
    function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// rtl/fsmc_phase_timer.sv - loadable down-counter timing every bus phase
module fsmc_phase_timer
    import fsmc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               tc_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/fsmc_mux_master.sv
// rtl/fsmc_mux_master.sv - single-access master for an address/data multiplexed FSMC bus
module fsmc_mux_master
    import fsmc_pkg::*;
#(
    parameter int ADDSET  = DEF_ADDSET,
    parameter int ADDHLD  = DEF_ADDHLD,
    parameter int DATAST  = DEF_DATAST,
    parameter int BUSTURN = DEF_BUSTURN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_i,
    input  logic                   wr_i,
    input  logic [FSMC_ADDR_W-1:0] addr_i,
    input  logic [FSMC_DATA_W-1:0] wdata_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [FSMC_DATA_W-1:0] rdata_o,
    output logic                   ne_o,
    output logic                   nadv_o,
    output logic                   noe_o,
    output logic                   nwe_o,
    output logic [2:0]             a_hi_o,
    output logic [FSMC_DATA_W-1:0] ad_out_o,
    output logic                   ad_oe_o,
    input  logic [FSMC_DATA_W-1:0] ad_in_i
);

    fsmc_state_e state_q, state_d;

    logic                   wr_q, wr_d;
    logic [FSMC_ADDR_W-1:0] addr_q, addr_d;
    logic [FSMC_DATA_W-1:0] wdata_q, wdata_d;
    logic [FSMC_DATA_W-1:0] rdata_q, rdata_d;

    logic                   ne_q, ne_d;
    logic                   nadv_q, nadv_d;
    logic                   noe_q, noe_d;
    logic                   nwe_q, nwe_d;
    logic [2:0]             a_hi_q, a_hi_d;
    logic [FSMC_DATA_W-1:0] ad_out_q, ad_out_d;
    logic                   ad_oe_q, ad_oe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   tmr_load;
    logic [TIMER_W-1:0]     tmr_val;
    logic                   tmr_tc;

    fsmc_phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // Next state, request capture, phase timer reloads and read data capture.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d  = ST_ADDR;
                    wr_d     = wr_i;
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(ADDSET);
                end
            end
            ST_ADDR: begin
                if (tmr_tc) begin
                    state_d  = ST_AHOLD;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(ADDHLD);
                end
            end
            ST_AHOLD: begin
                if (tmr_tc) begin
                    state_d  = ST_DATA;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(DATAST);
                end
            end
            ST_DATA: begin
                if (tmr_tc) begin
                    state_d = ST_DHOLD;
                    // Sample the bus on the edge closing the strobe window.
                    if (!wr_q) begin
                        rdata_d = ad_in_i;
                    end
                end
            end
            ST_DHOLD: begin
                state_d  = ST_TURN;
                tmr_load = 1'b1;
                tmr_val  = phase_load(BUSTURN);
            end
            ST_TURN: begin
                if (tmr_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values decoded from the upcoming state so every pin leaves a flop.
    always_comb begin
        ne_d     = 1'b1;
        nadv_d   = 1'b1;
        noe_d    = 1'b1;
        nwe_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        a_hi_d   = a_hi_q;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_TURN) && (state_q == ST_DHOLD);
        unique case (state_d)
            ST_ADDR: begin
                ne_d     = 1'b0;
                nadv_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d[FSMC_DATA_W-1:0];
                a_hi_d   = addr_d[FSMC_ADDR_W-1:FSMC_DATA_W];
            end
            ST_AHOLD: begin
                ne_d     = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d[FSMC_DATA_W-1:0];
            end
            ST_DATA: begin
                ne_d = 1'b0;
                if (wr_d) begin
                    nwe_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end else begin
                    noe_d = 1'b0;
                end
            end
            ST_DHOLD: begin
                ne_d = 1'b0;
                if (wr_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            default: begin
            end
        endcase
    end

    // State, captured request and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ne_q     <= 1'b1;
            nadv_q   <= 1'b1;
            noe_q    <= 1'b1;
            nwe_q    <= 1'b1;
            a_hi_q   <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ne_q     <= ne_d;
            nadv_q   <= nadv_d;
            noe_q    <= noe_d;
            nwe_q    <= nwe_d;
            a_hi_q   <= a_hi_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign ne_o     = ne_q;
    assign nadv_o   = nadv_q;
    assign noe_o    = noe_q;
    assign nwe_o    = nwe_q;
    assign a_hi_o   = a_hi_q;
    assign ad_out_o = ad_out_q;
    assign ad_oe_o  = ad_oe_q;

endmodule

// File: doc/fsmc_mux_master.md
FSMC_MUX_MASTER -- requirements
Module: fsmc_mux_master

Interface
REQ-001 Parameter ADDSET, default 2: cycles with NADV low and the address driven; legal range 1..15.
REQ-002 Parameter ADDHLD, default 1: cycles with NADV high and the address still driven; legal range 1..15.
REQ-003 Parameter DATAST, default 4: cycles with NWE or NOE low; legal range 1..255.
REQ-004 Parameter BUSTURN, default 1: cycles with NE high and the bus released after each access; legal range 1..15.
REQ-005 There shall be one clock. Reset is asynchronous and active-low. Ports are listed below.
REQ-006 CLK  in  1  single clock; all state changes on its rising edge.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 REQ  in  1  start request; sampled only in IDLE.
REQ-009 WR  in  1  1 = write access, 0 = read access; captured with REQ.
REQ-010 ADDR  in  19  access address {A18,A17,A16,AD}; captured with REQ.
REQ-011 WDATA  in  16  write data; captured with REQ.
REQ-012 BUSY  out  1  high whenever the state is not IDLE.
REQ-013 DONE  out  1  single-cycle completion pulse.
REQ-014 RDATA  out  16  last read data.
REQ-015 NE, NADV, NOE, NWE  out  1 each  active-low bus strobes.
REQ-016 A_HI  out  3  address bits 18..16.
REQ-017 AD_OUT  out  16  value driven onto the multiplexed bus.
REQ-018 AD_OE  out  1  bus drive enable; the top level builds the tristate from it.
REQ-019 AD_IN  in  16  multiplexed bus input.

Function
REQ-020 All bus outputs, BUSY and DONE shall come directly from registers, with no combinational path to any pin.
REQ-021 The state machine shall have the states IDLE, ADDR, AHOLD, DATA, DHOLD and TURN.
REQ-022 In IDLE, when REQ=1, the block shall capture WR, ADDR and WDATA and go to ADDR on the next edge.
REQ-023 ADDR state, held for ADDSET cycles: NE=0, NADV=0, AD_OE=1, AD_OUT=ADDR[15:0].
REQ-024 AHOLD state, held for ADDHLD cycles: NADV=1, NE=0, and AD_OUT still holds the address.
REQ-025 DATA state for a write, held for DATAST cycles: AD_OUT=WDATA, AD_OE=1, NWE=0.
REQ-026 DATA state for a read, held for DATAST cycles: AD_OE=0, NOE=0.
REQ-027 For a read, RDATA shall capture AD_IN on the edge that ends the last DATA cycle.
REQ-028 DHOLD state, one cycle: NWE=1, NOE=1, NE=0. For a write, WDATA stays driven.
REQ-029 TURN state, held for BUSTURN cycles: NE=1, AD_OE=0. After TURN the block returns to IDLE.
REQ-030 DONE shall be high for exactly the first TURN cycle.
REQ-031 A_HI shall hold the captured ADDR[18:16] from ADDR through TURN.
REQ-032 NE low time shall be ADDSET+ADDHLD+DATAST+1 cycles.
REQ-033 Total occupancy from REQ acceptance to the next acceptance shall be ADDSET+ADDHLD+DATAST+1+BUSTURN+1 cycles.
REQ-034 REQ while BUSY=1 shall be ignored, with no queueing.
REQ-035 If REQ is held high continuously, back-to-back accesses shall start, with NE high for at least BUSTURN+1 cycles between them.
REQ-036 NWE and NOE shall never be low at the same time.
REQ-037 AD_OE shall be 0 whenever NOE=0.
REQ-038 RDATA shall change only on read completion.
REQ-039 Write data and address changes on AD_OUT shall occur only while NWE=1.

Reset
REQ-040 RST_N=0 shall force the following at once, independent of CLK: state=IDLE, NE=NADV=NOE=NWE=1, AD_OE=0, AD_OUT=0, A_HI=0, BUSY=0, DONE=0, RDATA=0, and all counters to 0.
REQ-041 A reset during any non-IDLE state shall abort the access, produce no DONE, and leave RDATA at 0.
REQ-042 Out of reset, the first REQ shall be accepted on the first edge after RST_N deasserts.

Structure
REQ-043 Package fsmc_pkg shall hold:
- the state enumeration;
- address and data width constants (19 and 16);
- the default timing constants (2, 1, 4, 1).
REQ-044 One sub-module, fsmc_phase_timer, shall provide a loadable 8-bit down-counter with a terminal-count flag, shared by all timed states.

Verification
REQ-045 Write, defaults, ADDR=19'h51234, WDATA=16'hA5C3 -> required response:
- NADV low 2 cycles with AD_OUT=16'h1234 and A_HI=3'b101;
- NWE low 4 cycles with AD_OUT=16'hA5C3;
- NE low 8 cycles;
- DONE pulses once, 9 cycles after acceptance.
REQ-046 Read, defaults, ADDR=19'h7_8000, with the bench driving AD_IN=16'h3C5A during DATA -> required response:
- NOE low 4 cycles with AD_OE=0;
- RDATA=16'h3C5A when DONE is high.
REQ-047 REQ held high for 3 accesses -> exactly 3 DONE pulses, 10 cycles apart, with NE high for 2 cycles between accesses.
REQ-048 RST_N pulsed low in the 2nd DATA cycle of a write -> required response:
- all strobes return to 1 immediately;
- AD_OE=0;
- no DONE;
- the next REQ completes normally.
REQ-049 Overrides ADDSET=1, ADDHLD=1, DATAST=1, BUSTURN=1 -> NE low 4 cycles, and DONE 5 cycles after acceptance.
REQ-050 A REQ pulse during DATA -> ignored: one DONE only, and BUSY stays high until TURN ends.
